// File: rtl/intr_ctrl.sv
// Interrupt controller that synchronises NUM_SRC async lines and presents one prioritised request to the control FSM.
// Latency: an IRQ_IN edge first sampled at edge k gives pending at edge k+SYNC_STAGES and INTR at edge k+SYNC_STAGES+1.
// Backpressure: a request is held with a stable index until INT_TAKEN, then INTR is forced low for HOLDOFF cycles.
//
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_irq_in            asynchronous interrupt lines (active-high)
//   i_irq_en            per-source enable
//   i_csr_mie           global interrupt enable
//   i_int_taken         one-cycle acknowledge from the control FSM
//   o_intr              registered interrupt request
//   o_int_id            index of the requested source, valid while o_intr=1
//   o_int_pending       raw pending vector before enable masking
module intr_ctrl #(
    parameter int                 NUM_SRC     = 4,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_SRC-1:0] EDGE_MASK   = '1,
    parameter int                 HOLDOFF     = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_SRC-1:0]         i_irq_in,
    input  logic [NUM_SRC-1:0]         i_irq_en,
    input  logic                       i_csr_mie,
    input  logic                       i_int_taken,
    output logic                       o_intr,
    output logic [$clog2(NUM_SRC)-1:0] o_int_id,
    output logic [NUM_SRC-1:0]         o_int_pending
);

    localparam int ID_W  = $clog2(NUM_SRC);
    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Synchroniser chains and edge detector
    logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
    logic [NUM_SRC-1:0] r_s_d;
    logic [NUM_SRC-1:0] w_s;

    // Pending, FSM and output registers
    logic [NUM_SRC-1:0] r_pend;
    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_intr;
    logic [ID_W-1:0]    r_int_id;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pend_nxt;
    logic [NUM_SRC-1:0] w_elig;
    logic               w_win_vld;
    logic [ID_W-1:0]    w_win_id;
    logic               w_take;
    logic               w_intr_d;
    logic [ID_W-1:0]    w_int_id_d;
    logic [CNT_W-1:0]   w_cnt_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= i_irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // An acknowledge only counts while a request is outstanding.
    assign w_take = (r_state == ST_REQ) && i_int_taken;

    // Edge-type bits: a new rising edge beats a same-cycle acknowledge so the event is not lost.
    // Level-type bits simply mirror the synchronised line.
    assign w_set      = w_s & ~r_s_d & EDGE_MASK;
    assign w_clr      = w_take ? (EDGE_MASK & (NUM_SRC'(1) << r_int_id)) : '0;
    assign w_pend_nxt = (w_s & ~EDGE_MASK) | (EDGE_MASK & (w_set | (r_pend & ~w_clr)));

    assign w_elig    = r_pend & i_irq_en;
    assign w_win_vld = |w_elig;

    // Lowest index wins: scan downwards so the last hit is the lowest set bit.
    always_comb begin
        w_win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_id = ID_W'(i);
            end
        end
    end

    // State register together with the registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_intr   <= 1'b0;
            r_int_id <= '0;
            r_cnt    <= '0;
            r_pend   <= '0;
            r_s_d    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_intr   <= w_intr_d;
            r_int_id <= w_int_id_d;
            r_cnt    <= w_cnt_d;
            r_pend   <= w_pend_nxt;
            r_s_d    <= w_s;
        end
    end

    // Next-state logic. Once in REQ nothing but the acknowledge moves us.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_csr_mie && w_win_vld) w_state_nxt = ST_REQ;
            ST_REQ:  if (i_int_taken)            w_state_nxt = ST_HOLD;
            ST_HOLD: if (r_cnt == '0)            w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: values loaded into the output registers at the next edge.
    always_comb begin
        w_intr_d   = (w_state_nxt == ST_REQ);
        w_int_id_d = r_int_id;
        w_cnt_d    = r_cnt;
        if (r_state == ST_IDLE && w_state_nxt == ST_REQ) begin
            w_int_id_d = w_win_id;
        end
        if (w_take) begin
            w_cnt_d = CNT_W'(HOLDOFF - 1);
        end else if (r_state == ST_HOLD && r_cnt != '0) begin
            w_cnt_d = r_cnt - CNT_W'(1);
        end
    end

    assign o_intr        = r_intr;
    assign o_int_id      = r_int_id;
    assign o_int_pending = r_pend;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

    localparam int         NS = 4;
    localparam int         SS = 2;
    localparam logic [3:0] EM = 4'b1110;
    localparam int         HO = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] irq = '0;
    logic [3:0] en = '0;
    logic       mie = 1'b0;
    logic       take = 1'b0;
    logic       intr;
    logic [1:0] int_id;
    logic [3:0] pend;

    int n_chk = 0;
    int n_fail = 0;

    intr_ctrl #(
        .NUM_SRC    (NS),
        .SYNC_STAGES(SS),
        .EDGE_MASK  (EM),
        .HOLDOFF    (HO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_irq_in     (irq),
        .i_irq_en     (en),
        .i_csr_mie    (mie),
        .i_int_taken  (take),
        .o_intr       (intr),
        .o_int_id     (int_id),
        .o_int_pending(pend)
    );

    always #5 clk = ~clk;

    // Reference model: a delay line for the synchroniser, a pending set,
    // a request flag and a count of remaining quiet cycles after an acknowledge.
    logic [3:0] q_sync[$];
    logic [3:0] m_sd = '0;
    logic [3:0] m_pend = '0;
    bit         m_req = 0;
    int         m_id = 0;
    int         m_quiet = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] i_irq, input logic [3:0] i_en,
                              input logic i_mie, input logic i_take);
        logic [3:0] s;
        logic [3:0] elig;
        logic [3:0] np;
        if (!r) begin
            m_pend = '0; m_req = 0; m_id = 0; m_quiet = 0; m_sd = '0;
            q_sync.delete();
            repeat (SS) q_sync.push_back(4'h0);
        end else begin
            s    = q_sync[0];
            elig = m_pend & i_en;
            for (int i = 0; i < NS; i++) begin
                if (EM[i]) np[i] = (s[i] && !m_sd[i]) || (m_pend[i] && !(m_req && i_take && m_id == i));
                else       np[i] = s[i];
            end
            if (m_req) begin
                if (i_take) begin
                    m_req   = 0;
                    m_quiet = HO;
                end
            end else if (m_quiet > 0) begin
                m_quiet--;
            end else if (i_mie && elig != 0) begin
                m_req = 1;
                for (int i = NS - 1; i >= 0; i--) if (elig[i]) m_id = i;
            end
            m_pend = np;
            m_sd   = s;
            q_sync.push_back(i_irq);
            void'(q_sync.pop_front());
        end
    endtask

    // One clock: drive inputs, advance the model, then compare just after the edge.
    task automatic cyc(input logic r, input logic [3:0] i_irq, input logic [3:0] i_en,
                       input logic i_mie, input logic i_take);
        rst_n = r; irq = i_irq; en = i_en; mie = i_mie; take = i_take;
        model_step(r, i_irq, i_en, i_mie, i_take);
        @(posedge clk);
        #1;
        chk("intr", 32'(intr), 32'(m_req));
        chk("int_id", 32'(int_id), 32'(m_id));
        chk("pending", 32'(pend), 32'(m_pend));
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) cyc(1, 4'h0, 4'hF, 1, intr);
        chk("drained_intr", 32'(intr), 32'd0);
        chk("drained_pend", 32'(pend), 32'd0);
    endtask

    initial begin
        repeat (SS) q_sync.push_back(4'h0);

        // Reset state, then reset held with all lines high
        cyc(0, 4'h0, 4'h0, 0, 0);
        chk("rst_intr", 32'(intr), 32'd0);
        chk("rst_id", 32'(int_id), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        for (int n = 0; n < 3; n++) begin
            cyc(0, 4'hF, 4'hF, 1, 0);
            chk("rst_hold_intr", 32'(intr), 32'd0);
            chk("rst_hold_pend", 32'(pend), 32'd0);
        end
        for (int n = 0; n < 3; n++) begin
            cyc(1, 4'hF, 4'hF, 1, 0);
            chk("rel_intr_low", 32'(intr), 32'd0);
        end
        cyc(1, 4'hF, 4'hF, 1, 0);
        chk("rel_intr_rise", 32'(intr), 32'd1);
        chk("rel_id", 32'(int_id), 32'd0);
        cyc(1, 4'h0, 4'hF, 1, 1);
        drain();

        // Single edge source on line 2
        cyc(1, 4'h4, 4'hF, 1, 0);
        cyc(1, 4'h0, 4'hF, 1, 0);
        chk("e2_pend_k1", 32'(pend), 32'h0);
        cyc(1, 4'h0, 4'hF, 1, 0);
        chk("e2_pend_k2", 32'(pend), 32'h4);
        chk("e2_intr_k2", 32'(intr), 32'd0);
        cyc(1, 4'h0, 4'hF, 1, 0);
        chk("e2_intr_k3", 32'(intr), 32'd1);
        chk("e2_id_k3", 32'(int_id), 32'd2);
        cyc(1, 4'h0, 4'hF, 1, 1);
        chk("e2_taken_intr", 32'(intr), 32'd0);
        chk("e2_taken_pend", 32'(pend), 32'h0);
        repeat (3) cyc(1, 4'h0, 4'hF, 1, 0);

        // Priority between lines 1 and 3, and the holdoff gap
        cyc(1, 4'hA, 4'hF, 1, 0);
        repeat (3) cyc(1, 4'h0, 4'hF, 1, 0);
        chk("pri_intr", 32'(intr), 32'd1);
        chk("pri_id_first", 32'(int_id), 32'd1);
        cyc(1, 4'h0, 4'hF, 1, 1);
        chk("pri_gap0", 32'(intr), 32'd0);
        cyc(1, 4'h0, 4'hF, 1, 0);
        chk("pri_gap1", 32'(intr), 32'd0);
        cyc(1, 4'h0, 4'hF, 1, 0);
        chk("pri_gap_idle", 32'(intr), 32'd0);
        cyc(1, 4'h0, 4'hF, 1, 0);
        chk("pri_second_intr", 32'(intr), 32'd1);
        chk("pri_id_second", 32'(int_id), 32'd3);
        cyc(1, 4'h0, 4'hF, 1, 1);
        drain();

        // Global masking, and a request that survives MIE dropping
        repeat (20) cyc(1, 4'h1, 4'hF, 0, 0);
        chk("mask_intr", 32'(intr), 32'd0);
        chk("mask_pend", 32'(pend), 32'h1);
        cyc(1, 4'h1, 4'hF, 1, 0);
        chk("unmask_intr", 32'(intr), 32'd1);
        chk("unmask_id", 32'(int_id), 32'd0);
        repeat (3) cyc(1, 4'h1, 4'hF, 0, 0);
        chk("mie_drop_hold", 32'(intr), 32'd1);
        cyc(1, 4'h1, 4'hF, 0, 1);
        chk("mie_drop_taken", 32'(intr), 32'd0);

        // Level source 0 held high keeps re-requesting
        repeat (3) cyc(1, 4'h1, 4'hF, 1, 0);
        chk("lvl_req", 32'(intr), 32'd1);
        cyc(1, 4'h1, 4'hF, 1, 1);
        chk("lvl_pend_kept", 32'(pend), 32'h1);
        chk("lvl_taken_intr", 32'(intr), 32'd0);
        repeat (2) cyc(1, 4'h1, 4'hF, 1, 0);
        chk("lvl_gap", 32'(intr), 32'd0);
        cyc(1, 4'h1, 4'hF, 1, 0);
        chk("lvl_rereq", 32'(intr), 32'd1);
        chk("lvl_rereq_id", 32'(int_id), 32'd0);
        cyc(1, 4'h0, 4'hF, 1, 1);
        cyc(1, 4'h0, 4'hF, 1, 0);
        chk("lvl_pend_lag", 32'(pend), 32'h1);
        cyc(1, 4'h0, 4'hF, 1, 0);
        chk("lvl_pend_clear", 32'(pend), 32'h0);
        repeat (3) cyc(1, 4'h0, 4'hF, 1, 0);

        // New edge on line 2 lands on the acknowledge edge for line 2
        cyc(1, 4'h4, 4'hF, 1, 0);
        repeat (3) cyc(1, 4'h0, 4'hF, 1, 0);
        chk("col_req_id", 32'(int_id), 32'd2);
        cyc(1, 4'h4, 4'hF, 1, 0);
        cyc(1, 4'h4, 4'hF, 1, 0);
        cyc(1, 4'h0, 4'hF, 1, 1);
        chk("col_pend_kept", 32'(pend), 32'h4);
        chk("col_intr_low", 32'(intr), 32'd0);
        repeat (3) cyc(1, 4'h0, 4'hF, 1, 0);
        chk("col_rereq", 32'(intr), 32'd1);
        chk("col_rereq_id", 32'(int_id), 32'd2);
        cyc(1, 4'h0, 4'hF, 1, 1);
        drain();

        // Spurious acknowledge while idle
        cyc(1, 4'h0, 4'hF, 1, 1);
        chk("spur_intr", 32'(intr), 32'd0);
        chk("spur_pend", 32'(pend), 32'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] r_irq;
            r_irq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : irq;
            cyc(($urandom_range(0, 299) != 0),
                r_irq,
                ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                ($urandom_range(0, 9) != 0),
                intr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
